univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop with clear/preset: a WIDTH-bit register bank with synchronous clear, synchronous preset, enable, and a mode-selected datapath.
- Modes: hold, shift, rotate, parallel load, and a multi-cycle "shift right by N" command with busy/done handshake.
- Used as the lab's general storage/serialiser element wherever discrete flip-flops were previously instantiated.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- PRST_VAL, all ones ({WIDTH{1'b1}}), value loaded by prst.
- CW, $clog2(WIDTH+1), width of cnt_in (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset; highest priority.
- prst  input  1  synchronous, active-high preset; q <= PRST_VAL.
- en  input  1  enables mode operation when not busy.
- mode  input  3  operation select (see Behaviour).
- d_in  input  WIDTH  parallel load data.
- ser_in_r  input  1  serial input entering MSB on right shift.
- ser_in_l  input  1  serial input entering LSB on left shift.
- cnt_in  input  CW  shift count for multi-shift command.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  bitwise complement of q; always ~q, including during reset.
- ser_out_r  output  1  q[0].
- ser_out_l  output  1  q[WIDTH-1].
- busy  output  1  multi-shift in progress.
- done  output  1  one-cycle pulse when a multi-shift completes.

Behaviour:
- Reset (clr=1 at edge): q=0, q_bar=all ones, busy=0, done=0, internal remaining-count rem=0. Aborts any multi-shift; no done pulse.
- Priority at each edge: clr > prst > active multi-shift > (en && mode) > hold.
- prst=1, clr=0: q<=PRST_VAL; busy<=0, done<=0, rem<=0. Aborts multi-shift; no done pulse.
- en=0 and not busy: hold; done<=0.
- mode (en=1, not busy):
  - 000 hold.
  - 001 shift right: q<={ser_in_r, q[WIDTH-1:1]}.
  - 010 shift left: q<={q[WIDTH-2:0], ser_in_l}.
  - 011 load: q<=d_in.
  - 100 rotate right.
  - 101 rotate left.
  - 110 multi-shift start.
  - 111 reserved = hold.
- Multi-shift FSM, states IDLE / SHIFT (busy = state==SHIFT):
  - IDLE, en=1, mode=110: accept. N = min(cnt_in, WIDTH). q unchanged on the accept edge.
  - If N=0: stay IDLE, done<=1 next cycle.
  - Else: rem<=N, go to SHIFT.
  - SHIFT, each edge: q shifts right by one (ser_in_r sampled that edge), rem<=rem-1.
  - When rem==1: go to IDLE, done<=1.
  - Net effect: N shifts on the N edges after accept; busy high exactly N cycles; done high for the single cycle after the last shift edge.
  - While busy, en/mode/d_in/cnt_in are ignored; a start request is not queued.
  - Back-to-back: a new start is accepted in the cycle done is high, since the FSM is IDLE.
- done is 0 in every cycle other than the completion pulse.
- Outputs are registered or direct functions of registered q; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8. Reset: drive clr=1 with random inputs for 2 edges -> q=8'h00, q_bar=8'hFF, busy=0, done=0. Then prst=1 -> q=8'hFF, q_bar=8'h00.
- Load and shift: load d_in=8'hA5; mode=001 with ser_in_r=1 -> q=8'hD2, ser_out_r=0. Then mode=010 with ser_in_l=0 -> q=8'hA4. With en=0, q holds for 3 cycles.
- Rotate: from q=8'h81, mode=100 -> 8'hC0; then mode=101 twice -> 8'h03.
- Multi-shift: load 8'hF0; start with cnt_in=3, ser_in_r=0 -> busy high for exactly 3 cycles; mode=011 with d_in=8'h55 during busy is ignored; q=8'h1E; done high for 1 cycle. With cnt_in=0 -> done pulse next cycle, busy never asserts, q unchanged. With cnt_in=15 -> clamped to 8; busy 8 cycles; q=8'h00.
- Abort: start cnt_in=5; after 2 busy cycles assert prst -> q=8'hFF, busy=0, no done pulse. Repeat with clr -> q=8'h00.
- Back-to-back: issue a second start (cnt_in=2) in the done cycle of the first -> accepted; busy high 2 cycles; done pulses again; total shifts equal the sum of both counts.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load and a
// multi-cycle shift-right-by-N command with busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] PRST_VAL = {WIDTH{1'b1}},
  parameter int unsigned CW = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             prst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [CW-1:0]    cnt_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    rem;
  logic [CW-1:0]    rem_next;
  logic [WIDTH-1:0] q_next;
  logic             done_next;
  logic [CW-1:0]    n_cnt;

  // Counts above WIDTH would only shift in more ser_in_r bits.
  assign n_cnt = (cnt_in > CW'(WIDTH)) ? CW'(WIDTH) : cnt_in;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else if (prst) begin
      state <= IDLE;
      q     <= PRST_VAL;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      rem   <= rem_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q;
    rem_next   = rem;
    done_next  = 1'b0;
    if (state == SHIFT) begin
      q_next   = {ser_in_r, q[WIDTH-1:1]};
      rem_next = rem - CW'(1);
      if (rem == CW'(1)) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end else if (en) begin
      unique case (mode)
        3'b000: q_next = q;
        3'b001: q_next = {ser_in_r, q[WIDTH-1:1]};
        3'b010: q_next = {q[WIDTH-2:0], ser_in_l};
        3'b011: q_next = d_in;
        3'b100: q_next = {q[0], q[WIDTH-1:1]};
        3'b101: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        3'b110: begin
          if (n_cnt == '0) begin
            done_next = 1'b1;
          end else begin
            rem_next   = n_cnt;
            state_next = SHIFT;
          end
        end
        3'b111: q_next = q;
        default: q_next = q;
      endcase
    end
  end

  assign q_bar     = ~q;
  assign ser_out_r = q[0];
  assign ser_out_l = q[WIDTH-1];
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): stimulus pushes
// expected post-edge state, a monitor pops and compares each cycle.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          clr, prst, en;
  logic [2:0]    mode;
  logic [W-1:0]  d_in;
  logic          ser_in_r, ser_in_l;
  logic [CW-1:0] cnt_in;
  logic [W-1:0]  q, q_bar;
  logic          ser_out_r, ser_out_l, busy, done;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .prst(prst), .en(en),
    .mode(mode), .d_in(d_in),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
    .cnt_in(cnt_in), .q(q), .q_bar(q_bar),
    .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Monitor: every post-edge state has an expected entry.
  initial begin
    exp_t e;
    logic [2*W+3:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {q, q_bar, ser_out_l, ser_out_r, busy, done};
        req = {e.q, ~e.q, e.q[W-1], e.q[0], e.busy, e.done};
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: q=%h q_bar=%h sl=%b sr=%b busy=%b done=%b, required q=%h q_bar=%h sl=%b sr=%b busy=%b done=%b",
          e.nm, q, q_bar, ser_out_l, ser_out_r, busy, done,
          e.q, ~e.q, e.q[W-1], e.q[0], e.busy, e.done);
      end
    end
  end

  task automatic cyc(input string nm, input logic [W-1:0] eq,
                     input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    e.nm = nm; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive(input logic e_, input logic [2:0] m,
                       input logic [W-1:0] d, input logic sr,
                       input logic sl, input logic [CW-1:0] c);
    en = e_; mode = m; d_in = d;
    ser_in_r = sr; ser_in_l = sl; cnt_in = c;
  endtask

  initial begin
    logic [W-1:0] v;
    clr = 1'b1; prst = 1'($urandom);
    drive(1'b1, 3'($urandom), W'($urandom), 1'($urandom),
          1'($urandom), CW'($urandom));
    cyc("reset0", 8'h00, 0, 0);
    drive(1'b1, 3'b110, W'($urandom), 1'b1, 1'b1, CW'(3));
    cyc("reset1", 8'h00, 0, 0);
    clr = 1'b0; prst = 1'b1;
    drive(0, 3'b000, 8'h00, 0, 0, 0);
    cyc("preset", 8'hFF, 0, 0);
    prst = 1'b0;

    drive(1, 3'b011, 8'hA5, 0, 0, 0);
    cyc("load_a5", 8'hA5, 0, 0);
    drive(1, 3'b001, 8'h00, 1, 0, 0);
    cyc("shr", 8'hD2, 0, 0);
    drive(1, 3'b010, 8'h00, 0, 0, 0);
    cyc("shl", 8'hA4, 0, 0);
    drive(0, 3'b011, 8'hFF, 1, 1, 3);
    for (int i = 0; i < 3; i++) cyc("hold_en0", 8'hA4, 0, 0);
    drive(1, 3'b111, 8'hFF, 1, 1, 0);
    cyc("mode111", 8'hA4, 0, 0);
    drive(1, 3'b000, 8'hFF, 1, 1, 0);
    cyc("mode000", 8'hA4, 0, 0);

    drive(1, 3'b011, 8'h81, 0, 0, 0);
    cyc("load_81", 8'h81, 0, 0);
    drive(1, 3'b100, 8'h00, 0, 0, 0);
    cyc("ror", 8'hC0, 0, 0);
    drive(1, 3'b101, 8'h00, 0, 0, 0);
    cyc("rol1", 8'h81, 0, 0);
    cyc("rol2", 8'h03, 0, 0);

    drive(1, 3'b011, 8'hF0, 0, 0, 0);
    cyc("load_f0", 8'hF0, 0, 0);
    drive(1, 3'b110, 8'h00, 0, 0, 3);
    cyc("ms3_acc", 8'hF0, 1, 0);
    drive(1, 3'b011, 8'h55, 0, 0, 0);
    cyc("ms3_s1", 8'h78, 1, 0);
    cyc("ms3_s2", 8'h3C, 1, 0);
    drive(0, 3'b011, 8'h55, 0, 0, 0);
    cyc("ms3_done", 8'h1E, 0, 1);
    cyc("ms3_after", 8'h1E, 0, 0);

    drive(1, 3'b110, 8'h00, 1, 0, 0);
    cyc("ms0_done", 8'h1E, 0, 1);
    drive(0, 3'b000, 8'h00, 0, 0, 0);
    cyc("ms0_after", 8'h1E, 0, 0);

    drive(1, 3'b110, 8'h00, 0, 0, 15);
    cyc("ms15_acc", 8'h1E, 1, 0);
    v = 8'h1E;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) en = 1'b0;
      v = v >> 1;
      cyc("ms15_shift", v, k < 8, k == 8);
    end
    cyc("ms15_after", 8'h00, 0, 0);

    drive(1, 3'b110, 8'h00, 1, 0, 5);
    cyc("abp_acc", 8'h00, 1, 0);
    en = 1'b0;
    cyc("abp_s1", 8'h80, 1, 0);
    cyc("abp_s2", 8'hC0, 1, 0);
    prst = 1'b1;
    cyc("abp_prst", 8'hFF, 0, 0);
    prst = 1'b0;
    cyc("abp_nodone", 8'hFF, 0, 0);
    cyc("abp_idle", 8'hFF, 0, 0);

    drive(1, 3'b110, 8'h00, 0, 0, 5);
    cyc("abc_acc", 8'hFF, 1, 0);
    en = 1'b0;
    cyc("abc_s1", 8'h7F, 1, 0);
    cyc("abc_s2", 8'h3F, 1, 0);
    clr = 1'b1;
    cyc("abc_clr", 8'h00, 0, 0);
    clr = 1'b0;
    cyc("abc_nodone", 8'h00, 0, 0);

    drive(1, 3'b011, 8'hFF, 0, 0, 0);
    cyc("b2b_load", 8'hFF, 0, 0);
    drive(1, 3'b110, 8'h00, 0, 0, 3);
    cyc("b2b_acc1", 8'hFF, 1, 0);
    cnt_in = CW'(2);
    cyc("b2b_s1", 8'h7F, 1, 0);
    cyc("b2b_s2", 8'h3F, 1, 0);
    cyc("b2b_done1", 8'h1F, 0, 1);
    cyc("b2b_acc2", 8'h1F, 1, 0);
    en = 1'b0;
    cyc("b2b_s4", 8'h0F, 1, 0);
    cyc("b2b_done2", 8'h07, 0, 1);
    cyc("b2b_after", 8'h07, 0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
